prod_obs_monitor: RTL

//  Downstream consumer of the self-composed product harness. Takes the per-copy

---
 rtl/prod_obs_monitor.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/prod_obs_monitor.sv
// Relational observation monitor: re-aligns Left/Right event streams through
// one small FIFO per side and raises sticky failure flags on the first divergence.
module prod_obs_monitor #(
  parameter int W        = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_SKEW = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             obs_valid_l_i,
  input  logic [W-1:0]     obs_data_l_i,
  input  logic             obs_valid_r_i,
  input  logic [W-1:0]     obs_data_r_i,
  output logic [CNT_W-1:0] cmp_count_o,
  output logic             violation_o,
  output logic             overflow_o,
  output logic             timeout_o,
  output logic [W-1:0]     mismatch_l_o,
  output logic [W-1:0]     mismatch_r_o,
  output logic             fail_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;
  localparam int SW = $clog2(MAX_SKEW + 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FAIL = 1'b1
  } state_t;

  state_t state_reg;

  logic            run;
  logic [1:0]      valid_s;
  logic [W-1:0]    data_s [2];
  logic [W-1:0]    head [2];
  logic [1:0]      nonempty;
  logic [1:0]      push_ok;
  logic [1:0]      drop;
  logic            pop;
  logic            heads_equal;
  logic            diff_hit;
  logic            one_side;
  logic            timeout_hit;
  logic [SW-1:0]   skew_reg;
  logic [SW-1:0]   skew_next;

  assign run       = (state_reg == ST_RUN);
  assign valid_s   = {obs_valid_r_i, obs_valid_l_i};
  assign data_s[0] = obs_data_l_i;
  assign data_s[1] = obs_data_r_i;

  // Pops look only at pre-edge occupancy, so a fresh pair is compared one edge later.
  assign pop         = run && (&nonempty);
  assign heads_equal = (head[0] == head[1]);
  assign diff_hit    = pop && !heads_equal;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      logic [W-1:0]  mem [DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [OW-1:0] occ_reg;
      logic          push_req;

      assign nonempty[gi] = (occ_reg != '0);
      assign head[gi]     = mem[rd_ptr_reg];
      assign push_req     = run && enable_i && valid_s[gi];
      // A full FIFO still accepts when its head leaves on the same edge.
      assign push_ok[gi]  = push_req && ((occ_reg != OW'(DEPTH)) || pop);
      assign drop[gi]     = push_req && !push_ok[gi];

      always_ff @(posedge clk_i) begin
        if (push_ok[gi]) begin
          mem[wr_ptr_reg] <= data_s[gi];
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          occ_reg    <= '0;
        end else begin
          if (push_ok[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
          end
          case ({push_ok[gi], pop})
            2'b10:   occ_reg <= occ_reg + OW'(1);
            2'b01:   occ_reg <= occ_reg - OW'(1);
            default: occ_reg <= occ_reg;
          endcase
        end
      end
    end
  endgenerate

  assign one_side    = run && (nonempty[0] ^ nonempty[1]);
  assign skew_next   = one_side ? (skew_reg + SW'(1)) : '0;
  assign timeout_hit = one_side && (skew_reg == SW'(MAX_SKEW - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= ST_RUN;
      skew_reg     <= '0;
      cmp_count_o  <= '0;
      violation_o  <= 1'b0;
      overflow_o   <= 1'b0;
      timeout_o    <= 1'b0;
      mismatch_l_o <= '0;
      mismatch_r_o <= '0;
      fail_o       <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          skew_reg <= skew_next;
          if (pop && heads_equal && (cmp_count_o != '1)) begin
            cmp_count_o <= cmp_count_o + CNT_W'(1);
          end
          if (diff_hit) begin
            violation_o  <= 1'b1;
            mismatch_l_o <= head[0];
            mismatch_r_o <= head[1];
          end
          if (|drop) begin
            overflow_o <= 1'b1;
          end
          if (timeout_hit) begin
            timeout_o <= 1'b1;
          end
          if (diff_hit || (|drop) || timeout_hit) begin
            state_reg <= ST_FAIL;
            fail_o    <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_FAIL;
          fail_o    <= 1'b1;
        end
      endcase
    end
  end

endmodule
